// File: rtl/udp_proto_pkg.sv
// Shared UDP protocol constants: packet magic/version, status packet layout and
// the sender state encoding. The panel writer imports the same magic/version.
package udp_proto_pkg;

    localparam int STATUS_PKT_LEN = 14;

    localparam int IDX_SEQ   = 4;
    localparam int IDX_FRAME = 6;
    localparam int IDX_ERR   = 10;
    localparam int IDX_FLAGS = 12;
    localparam int IDX_CSUM  = STATUS_PKT_LEN - 1;

    localparam logic [15:0] DEF_MAGIC    = 16'h4C43;
    localparam logic [7:0]  DEF_VERSION  = 8'h01;
    localparam logic [7:0]  DEF_PKT_TYPE = 8'h02;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/udp_status_sender_if.sv
// Byte-wide payload stream toward the Ethernet core's udp0 sink.
interface udp_status_sender_if;
    logic       valid;
    logic       last;
    logic       ready;
    logic [7:0] data;

    modport master (output valid, output last, output data, input ready);
    modport slave  (input valid, input last, input data, output ready);
endinterface

// File: rtl/udp_status_sender.sv
// Snapshots status counters on request and streams one 14-byte status datagram
// payload; one request can queue behind the packet in flight.
module udp_status_sender
    import udp_proto_pkg::*;
#(
    parameter logic [15:0] MAGIC    = DEF_MAGIC,
    parameter logic [7:0]  VERSION  = DEF_VERSION,
    parameter logic [7:0]  PKT_TYPE = DEF_PKT_TYPE
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       send_req,
    input  logic [31:0]                frame_cnt,
    input  logic [15:0]                err_cnt,
    input  logic [7:0]                 status_flags,
    udp_status_sender_if.master        udp0_sink,
    output logic                       busy,
    output logic [7:0]                 drop_cnt
);

    state_t      state, state_nxt;
    logic [3:0]  idx;
    logic [15:0] seq;
    logic        pending;

    logic [15:0] snap_seq;
    logic [31:0] snap_frame;
    logic [15:0] snap_err;
    logic [7:0]  snap_flags;
    logic [7:0]  csum;
    logic [7:0]  byte_sel;

    logic xfer, done, restart, capture;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // A request arriving with the final byte is served immediately, same as a pending one.
    always_comb begin
        xfer      = (state == SEND) && udp0_sink.ready;
        done      = xfer && (idx == 4'(IDX_CSUM));
        restart   = done && (pending || send_req);
        capture   = ((state == IDLE) && send_req) || restart;
        state_nxt = state;
        case (state)
            IDLE:    if (send_req) state_nxt = SEND;
            SEND:    if (done && !restart) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        byte_sel = 8'h00;
        case (idx)
            4'd0:               byte_sel = MAGIC[15:8];
            4'd1:               byte_sel = MAGIC[7:0];
            4'd2:               byte_sel = VERSION;
            4'd3:               byte_sel = PKT_TYPE;
            4'(IDX_SEQ):        byte_sel = snap_seq[15:8];
            4'(IDX_SEQ + 1):    byte_sel = snap_seq[7:0];
            4'(IDX_FRAME):      byte_sel = snap_frame[31:24];
            4'(IDX_FRAME + 1):  byte_sel = snap_frame[23:16];
            4'(IDX_FRAME + 2):  byte_sel = snap_frame[15:8];
            4'(IDX_FRAME + 3):  byte_sel = snap_frame[7:0];
            4'(IDX_ERR):        byte_sel = snap_err[15:8];
            4'(IDX_ERR + 1):    byte_sel = snap_err[7:0];
            4'(IDX_FLAGS):      byte_sel = snap_flags;
            4'(IDX_CSUM):       byte_sel = csum;
            default:            byte_sel = 8'h00;
        endcase
    end

    assign udp0_sink.valid = (state == SEND);
    assign udp0_sink.last  = (state == SEND) && (idx == 4'(IDX_CSUM));
    assign udp0_sink.data  = (state == SEND) ? byte_sel : 8'h00;
    assign busy            = (state != IDLE) || pending;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state    <= IDLE;
            idx      <= 4'd0;
            seq      <= 16'd0;
            pending  <= 1'b0;
            drop_cnt <= 8'd0;
        end else begin
            state <= state_nxt;
            if (done)
                seq <= seq + 16'd1;
            if (capture)
                idx <= 4'd0;
            else if (xfer)
                idx <= idx + 4'd1;
            if (state == SEND) begin
                if (send_req && pending)
                    drop_cnt <= sat_inc8(drop_cnt);
                if (done)
                    pending <= 1'b0;
                else if (send_req)
                    pending <= 1'b1;
            end
        end
    end

    // Snapshot and running checksum; a back-to-back snapshot carries the incremented seq.
    always_ff @(posedge clock) begin
        if (capture) begin
            snap_seq   <= done ? seq + 16'd1 : seq;
            snap_frame <= frame_cnt;
            snap_err   <= err_cnt;
            snap_flags <= status_flags;
            csum       <= 8'h00;
        end else if (xfer) begin
            csum <= csum ^ byte_sel;
        end
    end

endmodule

// File: tb/tb_udp_status_sender.sv
// Directed bench for udp_status_sender: packet content, backpressure, queuing,
// back-to-back, seq wrap, drop saturation and mid-packet reset.
module tb_udp_status_sender;

    logic        clock = 1'b0;
    logic        resetn;
    logic        send_req;
    logic [31:0] frame_cnt;
    logic [15:0] err_cnt;
    logic [7:0]  status_flags;
    logic        busy;
    logic [7:0]  drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [111:0] PKT1 = 112'h4C43_0102_0000_0102_0304_0A0B_5A53;

    udp_status_sender_if sink ();

    udp_status_sender dut (
        .clock        (clock),
        .resetn       (resetn),
        .send_req     (send_req),
        .frame_cnt    (frame_cnt),
        .err_cnt      (err_cnt),
        .status_flags (status_flags),
        .udp0_sink    (sink),
        .busy         (busy),
        .drop_cnt     (drop_cnt)
    );

    always #5 clock = ~clock;

    function automatic logic [111:0] build_pkt(input logic [15:0] s, input logic [31:0] f,
                                               input logic [15:0] e, input logic [7:0] fl);
        logic [103:0] body;
        logic [7:0]   x;
        body = {16'h4C43, 8'h01, 8'h02, s, f, e, fl};
        x = 8'h00;
        for (int i = 0; i < 13; i++) x ^= body[8*i +: 8];
        return {body, x};
    endfunction

    task automatic do_reset;
        resetn      = 1'b0;
        send_req    = 1'b0;
        sink.ready  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
    endtask

    task automatic start_pkt(input logic [31:0] f, input logic [15:0] e, input logic [7:0] fl);
        frame_cnt    = f;
        err_cnt      = e;
        status_flags = fl;
        send_req     = 1'b1;
        @(posedge clock);
        #1;
        send_req     = 1'b0;
        frame_cnt    = 32'hDEADBEEF;
        err_cnt      = 16'hFFFF;
        status_flags = 8'hFF;
    endtask

    // Gathers transferred bytes; raises send_req once when byte req_a / req_b is on the bus.
    task automatic collect(input int mode, input int req_a, input int req_b, input int stop_n,
                           output logic [111:0] pkt, output logic [13:0] lasts,
                           output int gaps, output int unstable, output bit tmo);
        int n, cyc, stall;
        bit tog, held, fa, fb;
        logic [7:0] hd, d;
        logic hl, v, r, la;
        n = 0; cyc = 0; stall = 0; tog = 1'b1; held = 1'b0; fa = 1'b0; fb = 1'b0;
        hd = 8'h00; hl = 1'b0;
        pkt = '0; lasts = '0; gaps = 0; unstable = 0; tmo = 1'b0;
        while (n < stop_n && cyc < 500) begin
            if (mode == 0) begin
                sink.ready = 1'b1;
            end else if (stall > 0) begin
                sink.ready = 1'b0;
                stall--;
            end else begin
                sink.ready = tog;
                tog = ~tog;
                if ($urandom_range(0, 3) == 0) stall = $urandom_range(0, 5);
            end
            send_req = 1'b0;
            if (sink.valid && n == req_a && !fa) begin send_req = 1'b1; fa = 1'b1; end
            if (sink.valid && n == req_b && !fb) begin send_req = 1'b1; fb = 1'b1; end
            v = sink.valid; r = sink.ready; d = sink.data; la = sink.last;
            if (held && v && (d !== hd || la !== hl)) unstable++;
            if (!v) gaps++;
            if (v && r) begin
                pkt[111 - 8*n -: 8] = d;
                lasts[n] = la;
                n++;
                held = 1'b0;
            end else if (v) begin
                held = 1'b1; hd = d; hl = la;
            end
            @(posedge clock);
            #1;
            cyc++;
        end
        send_req   = 1'b0;
        sink.ready = 1'b0;
        tmo = (n < stop_n);
    endtask

    task automatic test_reset;
        do_reset;
        n_checks++; if (sink.valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", sink.valid); end
        n_checks++; if (sink.last !== 1'b0) begin n_fail++; $display("FAIL rst_last: got %b want 0", sink.last); end
        n_checks++; if (sink.data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h want 00", sink.data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (drop_cnt !== 8'h00) begin n_fail++; $display("FAIL rst_drop: got %h want 00", drop_cnt); end
    endtask

    task automatic test_single;
        logic [111:0] pkt; logic [13:0] l; int g, u; bit t;
        do_reset;
        frame_cnt = 32'h01020304; err_cnt = 16'h0A0B; status_flags = 8'h5A; send_req = 1'b1;
        n_checks++; if (sink.valid !== 1'b0) begin n_fail++; $display("FAIL t1_valid_early: got %b want 0", sink.valid); end
        @(posedge clock); #1;
        send_req = 1'b0; frame_cnt = 32'hDEADBEEF; err_cnt = 16'hFFFF; status_flags = 8'hFF;
        n_checks++; if (sink.valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL t1_latency: got valid=%b busy=%b want 1 1", sink.valid, busy); end
        collect(0, -1, -1, 14, pkt, l, g, u, t);
        n_checks++; if (t) begin n_fail++; $display("FAIL t1_timeout: got timeout want 14 bytes"); end
        n_checks++; if (pkt !== PKT1) begin n_fail++; $display("FAIL t1_bytes: got %h want %h", pkt, PKT1); end
        n_checks++; if (l !== 14'h2000) begin n_fail++; $display("FAIL t1_last: got %h want 2000", l); end
        n_checks++; if (g !== 0) begin n_fail++; $display("FAIL t1_gaps: got %0d want 0", g); end
        n_checks++; if (sink.valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL t1_idle_after: got valid=%b busy=%b want 0 0", sink.valid, busy); end
        n_checks++; if (dut.seq !== 16'h0001) begin n_fail++; $display("FAIL t1_seq: got %h want 0001", dut.seq); end
    endtask

    task automatic test_backpressure;
        logic [111:0] pkt; logic [13:0] l; int g, u; bit t;
        do_reset;
        start_pkt(32'h01020304, 16'h0A0B, 8'h5A);
        collect(1, -1, -1, 14, pkt, l, g, u, t);
        n_checks++; if (t) begin n_fail++; $display("FAIL t2_timeout: got timeout want 14 bytes"); end
        n_checks++; if (pkt !== PKT1) begin n_fail++; $display("FAIL t2_bytes: got %h want %h", pkt, PKT1); end
        n_checks++; if (l !== 14'h2000) begin n_fail++; $display("FAIL t2_last: got %h want 2000", l); end
        n_checks++; if (u !== 0) begin n_fail++; $display("FAIL t2_stall_stable: got %0d changes want 0", u); end
        n_checks++; if (g !== 0) begin n_fail++; $display("FAIL t2_valid_drop: got %0d low cycles want 0", g); end
    endtask

    task automatic test_back_to_back;
        logic [111:0] pkt, exp; logic [13:0] l; int g, u; bit t;
        do_reset;
        start_pkt(32'h01020304, 16'h0A0B, 8'h5A);
        frame_cnt = 32'h11223344; err_cnt = 16'h5566; status_flags = 8'h77;
        collect(0, 5, 8, 14, pkt, l, g, u, t);
        n_checks++; if (t || pkt !== PKT1) begin n_fail++; $display("FAIL t3_pkt1: got %h tmo=%b want %h", pkt, t, PKT1); end
        n_checks++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL t3_drop: got %0d want 1", drop_cnt); end
        n_checks++; if (sink.valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL t3_no_bubble: got valid=%b busy=%b want 1 1", sink.valid, busy); end
        collect(0, -1, -1, 14, pkt, l, g, u, t);
        exp = build_pkt(16'h0001, 32'h11223344, 16'h5566, 8'h77);
        n_checks++; if (t || pkt !== exp) begin n_fail++; $display("FAIL t3_pkt2: got %h tmo=%b want %h", pkt, t, exp); end
        n_checks++; if (g !== 0 || l !== 14'h2000) begin n_fail++; $display("FAIL t3_pkt2_framing: got gaps=%0d last=%h want 0 2000", g, l); end
        n_checks++; if (busy !== 1'b0 || sink.valid !== 1'b0) begin n_fail++; $display("FAIL t3_busy_end: got busy=%b valid=%b want 0 0", busy, sink.valid); end
    endtask

    task automatic test_last_coincident;
        logic [111:0] pkt, exp; logic [13:0] l; int g, u; bit t;
        do_reset;
        start_pkt(32'hA1B2C3D4, 16'h1234, 8'h81);
        frame_cnt = 32'h0000FFFF; err_cnt = 16'h0F0F; status_flags = 8'h3C;
        collect(0, 13, -1, 14, pkt, l, g, u, t);
        exp = build_pkt(16'h0000, 32'hA1B2C3D4, 16'h1234, 8'h81);
        n_checks++; if (t || pkt !== exp) begin n_fail++; $display("FAIL t4_pkt1: got %h tmo=%b want %h", pkt, t, exp); end
        n_checks++; if (sink.valid !== 1'b1) begin n_fail++; $display("FAIL t4_no_gap: got valid=%b want 1", sink.valid); end
        collect(0, -1, -1, 14, pkt, l, g, u, t);
        exp = build_pkt(16'h0001, 32'h0000FFFF, 16'h0F0F, 8'h3C);
        n_checks++; if (t || pkt !== exp || g !== 0) begin n_fail++; $display("FAIL t4_pkt2: got %h gaps=%0d want %h gaps=0", pkt, g, exp); end
        n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL t4_drop: got %0d want 0", drop_cnt); end
    endtask

    task automatic test_wrap_saturate;
        logic [111:0] pkt, exp; logic [13:0] l; int g, u; bit t;
        do_reset;
        force dut.seq = 16'hFFFF;
        @(posedge clock); #1;
        release dut.seq;
        start_pkt(32'h00000001, 16'h0002, 8'h03);
        collect(0, -1, -1, 14, pkt, l, g, u, t);
        exp = build_pkt(16'hFFFF, 32'h00000001, 16'h0002, 8'h03);
        n_checks++; if (t || pkt !== exp) begin n_fail++; $display("FAIL t5_seq_ffff: got %h want %h", pkt, exp); end
        start_pkt(32'h00000001, 16'h0002, 8'h03);
        collect(0, -1, -1, 14, pkt, l, g, u, t);
        exp = build_pkt(16'h0000, 32'h00000001, 16'h0002, 8'h03);
        n_checks++; if (t || pkt !== exp) begin n_fail++; $display("FAIL t5_seq_wrap: got %h want %h", pkt, exp); end
        start_pkt(32'h0, 16'h0, 8'h0);
        sink.ready = 1'b0;
        send_req   = 1'b1;
        repeat (301) @(posedge clock);
        #1;
        send_req = 1'b0;
        n_checks++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL t5_drop_sat: got %0d want 255", drop_cnt); end
    endtask

    task automatic test_reset_mid;
        logic [111:0] pkt, exp; logic [13:0] l; int g, u; bit t;
        do_reset;
        start_pkt(32'h01020304, 16'h0A0B, 8'h5A);
        collect(0, 2, 3, 7, pkt, l, g, u, t);
        n_checks++; if (t || drop_cnt !== 8'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL t6_pre: got drop=%0d busy=%b tmo=%b want 1 1 0", drop_cnt, busy, t); end
        resetn = 1'b0;
        sink.ready = 1'b1;
        @(posedge clock); #1;
        resetn = 1'b1;
        sink.ready = 1'b0;
        n_checks++; if (sink.valid !== 1'b0 || sink.last !== 1'b0) begin n_fail++; $display("FAIL t6_valid: got valid=%b last=%b want 0 0", sink.valid, sink.last); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL t6_busy: got %b want 0", busy); end
        n_checks++; if (drop_cnt !== 8'd0) begin n_fail++; $display("FAIL t6_drop: got %0d want 0", drop_cnt); end
        start_pkt(32'hCAFEF00D, 16'hBEEF, 8'hC3);
        collect(0, -1, -1, 14, pkt, l, g, u, t);
        exp = build_pkt(16'h0000, 32'hCAFEF00D, 16'hBEEF, 8'hC3);
        n_checks++; if (t || pkt !== exp) begin n_fail++; $display("FAIL t6_new_pkt: got %h want %h", pkt, exp); end
    endtask

    initial begin
        resetn       = 1'b0;
        send_req     = 1'b0;
        frame_cnt    = 32'h0;
        err_cnt      = 16'h0;
        status_flags = 8'h0;
        sink.ready   = 1'b0;
        test_reset;
        test_single;
        test_backpressure;
        test_back_to_back;
        test_last_coincident;
        test_wrap_saturate;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
